// File: rtl/commit_redirect_pkg.sv
// Shared types and defaults for the commit-to-frontend redirect path.
// Imported by the redirect interface and the commit_redirect module.
package commit_redirect_pkg;

    localparam int unsigned PC_WIDTH_DEF     = 32;
    localparam int unsigned DRAIN_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        CAUSE_EXCP      = 2'd0,
        CAUSE_ERTN      = 2'd1,
        CAUSE_REFETCH   = 2'd2,
        CAUSE_IDLE_WAKE = 2'd3
    } redirect_cause_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_DRAIN,
        ST_IDLE
    } redirect_state_t;

    // Fixed-width view of one redirect request, for consumers that want it packed.
    typedef struct packed {
        logic                      valid;
        logic [PC_WIDTH_DEF-1:0]   pc;
        redirect_cause_t           cause;
    } redirect_req_t;

endpackage

// File: rtl/commit_redirect_if.sv
// Redirect request channel from the commit side to the frontend.
// The commit side is the master; the frontend answers with ready.
interface commit_redirect_if
    import commit_redirect_pkg::*;
#(
    parameter int unsigned PC_WIDTH = PC_WIDTH_DEF
);
    logic                valid;
    logic [PC_WIDTH-1:0] pc;
    redirect_cause_t     cause;
    logic                ready;

    modport master (output valid, output pc, output cause, input ready);
    modport slave  (input valid, input pc, input cause, output ready);
endinterface

// File: rtl/commit_redirect.sv
// Turns commit flush strobes into one registered frontend redirect, and keeps
// the backend held until the redirect is accepted and a drain window has elapsed.
module commit_redirect
    import commit_redirect_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int unsigned PC_WIDTH     = PC_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 excp_flush_i,
    input  logic                 ertn_flush_i,
    input  logic                 idle_flush_i,
    input  logic                 fetch_flush_i,
    input  logic                 icache_flush_i,
    input  logic                 excp_tlbrefill_i,
    input  logic [PC_WIDTH-1:0]  commit_pc_i,
    input  logic [PC_WIDTH-1:0]  csr_eentry_i,
    input  logic [PC_WIDTH-1:0]  csr_tlbrentry_i,
    input  logic [PC_WIDTH-1:0]  csr_era_i,
    commit_redirect_if.master    redirect,
    output logic                 backend_hold_o,
    output logic                 idle_o
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    redirect_state_t     state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    redirect_cause_t     cause_q, cause_d;

    logic [PC_WIDTH-1:0] excp_target;
    logic                refetch;

    assign excp_target = excp_tlbrefill_i ? csr_tlbrentry_i : csr_eentry_i;
    assign refetch     = fetch_flush_i | icache_flush_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        cause_d = cause_q;
        unique case (state_q)
            ST_RUN: begin
                if (excp_flush_i) begin
                    pc_d    = excp_target;
                    cause_d = CAUSE_EXCP;
                    state_d = ST_WAIT;
                end else if (ertn_flush_i) begin
                    pc_d    = csr_era_i;
                    cause_d = CAUSE_ERTN;
                    state_d = ST_WAIT;
                end else if (idle_flush_i) begin
                    state_d = ST_IDLE;
                end else if (refetch) begin
                    pc_d    = commit_pc_i + PC_WIDTH'(4);
                    cause_d = CAUSE_REFETCH;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect.ready) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d   = CNT_W'(DRAIN_CYCLES);
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // The cycle holding count 1 is the last drain cycle.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (excp_flush_i) begin
                    pc_d    = excp_target;
                    cause_d = CAUSE_IDLE_WAKE;
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            pc_q    <= '0;
            cause_q <= CAUSE_EXCP;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
        end
    end

    // All outputs decode straight from registers, so they carry one-cycle latency.
    assign redirect.valid = (state_q == ST_WAIT);
    assign redirect.pc    = pc_q;
    assign redirect.cause = cause_q;
    assign backend_hold_o = (state_q != ST_RUN);
    assign idle_o         = (state_q == ST_IDLE);

`ifndef SYNTHESIS
    a_no_excp_in_wait: assert property (@(posedge clk) disable iff (!rst)
        !(state_q == ST_WAIT && excp_flush_i));
`endif

endmodule

// File: tb/tb_commit_redirect.sv
// Directed bench for commit_redirect: exception, backpressure, priority,
// idle wake, PC wrap, async reset mid-WAIT, and a zero-length drain window.
`timescale 1ns/1ps
module tb_commit_redirect;
    import commit_redirect_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        excp, ertn, idle, fetch, icache, tlbrefill;
    logic [31:0] commit_pc, eentry, tlbrentry, era;
    logic        hold, idle_out;
    logic        excp0, hold0, idle0;

    int total = 0;
    int bad   = 0;

    commit_redirect_if #(.PC_WIDTH(32)) fe ();
    commit_redirect_if #(.PC_WIDTH(32)) fe0 ();
    assign fe0.ready = fe.ready;

    commit_redirect #(.DRAIN_CYCLES(2), .PC_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .excp_flush_i(excp), .ertn_flush_i(ertn), .idle_flush_i(idle),
        .fetch_flush_i(fetch), .icache_flush_i(icache),
        .excp_tlbrefill_i(tlbrefill), .commit_pc_i(commit_pc),
        .csr_eentry_i(eentry), .csr_tlbrentry_i(tlbrentry), .csr_era_i(era),
        .redirect(fe), .backend_hold_o(hold), .idle_o(idle_out)
    );

    commit_redirect #(.DRAIN_CYCLES(0), .PC_WIDTH(32)) dut0 (
        .clk(clk), .rst(rst),
        .excp_flush_i(excp0), .ertn_flush_i(1'b0), .idle_flush_i(1'b0),
        .fetch_flush_i(1'b0), .icache_flush_i(1'b0),
        .excp_tlbrefill_i(tlbrefill), .commit_pc_i(commit_pc),
        .csr_eentry_i(eentry), .csr_tlbrentry_i(tlbrentry), .csr_era_i(era),
        .redirect(fe0), .backend_hold_o(hold0), .idle_o(idle0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [31:0] pc,
                           input logic [1:0] cause, input logic h, input logic i);
        chk({tag, ".valid"}, 32'(fe.valid), 32'(v));
        chk({tag, ".pc"},    fe.pc,         pc);
        chk({tag, ".cause"}, 32'(fe.cause), 32'(cause));
        chk({tag, ".hold"},  32'(hold),     32'(h));
        chk({tag, ".idle"},  32'(idle_out), 32'(i));
    endtask

    initial begin
        rst = 1'b0;
        {excp, ertn, idle, fetch, icache, tlbrefill, excp0} = '0;
        commit_pc = '0; eentry = '0; tlbrentry = '0; era = '0;
        fe.ready = 1'b0;

        tick(); tick();
        chk_all("reset", 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        chk_all("post_reset", 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);

        // Exception redirect with ready already high; dut0 has no drain window.
        fe.ready = 1'b1; eentry = 32'h1C008000; tlbrefill = 1'b0;
        excp = 1'b1; excp0 = 1'b1;
        tick();
        excp = 1'b0; excp0 = 1'b0;
        chk_all("excp_wait", 1'b1, 32'h1C008000, 2'd0, 1'b1, 1'b0);
        chk("d0_wait_valid", 32'(fe0.valid), 32'd1);
        chk("d0_wait_hold", 32'(hold0), 32'd1);
        tick();
        chk_all("excp_drain1", 1'b0, 32'h1C008000, 2'd0, 1'b1, 1'b0);
        chk("d0_run_valid", 32'(fe0.valid), 32'd0);
        chk("d0_run_hold", 32'(hold0), 32'd0);
        chk("d0_run_idle", 32'(idle0), 32'd0);
        tick();
        chk("excp_drain2.hold", 32'(hold), 32'd1);
        tick();
        chk_all("excp_run", 1'b0, 32'h1C008000, 2'd0, 1'b0, 1'b0);

        // ertn under backpressure; a fetch strobe during WAIT is ignored.
        fe.ready = 1'b0; era = 32'h1C000100; commit_pc = 32'h1C000500;
        ertn = 1'b1;
        tick();
        ertn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_all($sformatf("bp_wait%0d", i), 1'b1, 32'h1C000100, 2'd1, 1'b1, 1'b0);
            fetch = (i == 2);
            tick();
        end
        fetch = 1'b0;
        chk_all("bp_still", 1'b1, 32'h1C000100, 2'd1, 1'b1, 1'b0);
        fe.ready = 1'b1;
        tick();
        chk_all("bp_accepted", 1'b0, 32'h1C000100, 2'd1, 1'b1, 1'b0);
        tick(); tick();
        chk_all("bp_run", 1'b0, 32'h1C000100, 2'd1, 1'b0, 1'b0);

        // Priority: excp wins over ertn and fetch; a DRAIN strobe is ignored.
        tlbrefill = 1'b1; tlbrentry = 32'h1C00F000; era = 32'h1C000300;
        excp = 1'b1; ertn = 1'b1; fetch = 1'b1;
        tick();
        {excp, ertn, fetch} = '0;
        chk_all("prio_wait", 1'b1, 32'h1C00F000, 2'd0, 1'b1, 1'b0);
        tick();
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        chk_all("prio_drain2", 1'b0, 32'h1C00F000, 2'd0, 1'b1, 1'b0);
        tick();
        chk_all("prio_run", 1'b0, 32'h1C00F000, 2'd0, 1'b0, 1'b0);

        // IDLE: other strobes ignored, excp wakes with cause 3.
        tlbrefill = 1'b0; eentry = 32'h1C008000;
        idle = 1'b1;
        tick();
        idle = 1'b0;
        chk_all("idle_enter", 1'b0, 32'h1C00F000, 2'd0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            fetch  = (i % 3 == 0);
            ertn   = (i % 3 == 1);
            icache = (i % 5 == 2);
            idle   = (i == 7);
            tick();
            chk($sformatf("idle_v%0d", i), 32'(fe.valid), 32'd0);
            chk($sformatf("idle_i%0d", i), 32'(idle_out), 32'd1);
        end
        {fetch, ertn, icache, idle} = '0;
        fe.ready = 1'b0;
        excp = 1'b1;
        tick();
        excp = 1'b0;
        chk_all("wake_wait", 1'b1, 32'h1C008000, 2'd3, 1'b1, 1'b0);
        fe.ready = 1'b1;
        tick(); tick(); tick();
        chk_all("wake_run", 1'b0, 32'h1C008000, 2'd3, 1'b0, 1'b0);

        // Refetch target wraps; cacop refetch takes the same path.
        commit_pc = 32'hFFFFFFFC;
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        chk_all("wrap_wait", 1'b1, 32'h00000000, 2'd2, 1'b1, 1'b0);
        tick(); tick(); tick();
        commit_pc = 32'h1C000010;
        icache = 1'b1;
        tick();
        icache = 1'b0;
        chk_all("icache_wait", 1'b1, 32'h1C000014, 2'd2, 1'b1, 1'b0);
        tick(); tick(); tick();
        chk("icache_run.hold", 32'(hold), 32'd0);

        // Asynchronous reset mid-WAIT discards the pending redirect.
        fe.ready = 1'b0; era = 32'h1C000200;
        ertn = 1'b1;
        tick();
        ertn = 1'b0;
        chk("rw_pre.valid", 32'(fe.valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_all("rw_async", 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        chk_all("rw_run", 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
        tick();
        chk_all("rw_run2", 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
